// File: rtl/mtime_reader.sv
// mtime_reader: fetches one 64-bit timer sample over an AXI-lite read port.
// The low word is read first, then the high word latched by that low read.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid / req_ready     client request for one sample (ready only when idle)
//   resp_valid / resp_ready   response handshake
//   resp_data [63:0]          {hi, lo}; {32'b0, lo} after a low-word error
//   resp_err                  non-OKAY rresp, or a read timed out
//   arvalid/arready/araddr    AXI-lite read address channel
//   rvalid/rready/rdata/rresp AXI-lite read data channel
//
// Parameters: BASE_ADDR (low word; high word at BASE_ADDR+4),
//             TIMEOUT_CYCLES (read-data wait limit, timeout build only).
// Build option: define MTIME_READER_TIMEOUT_EN to bound the wait for rvalid.

module mtime_reader #(
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp
);

    typedef enum logic [2:0] {
        IDLE,
        AR_LO,
        R_LO,
        AR_HI,
        R_HI,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic        err_q, err_d;
    logic        timeout;

`ifdef MTIME_READER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts cycles spent in a read-data state; zero on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == R_LO || state_q == R_HI) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES));
`else
    // No limit: the read-data states wait for rvalid forever.
    assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

    // Outputs depend only on state, so arvalid/araddr cannot move
    // while an address phase waits for arready.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        araddr     = BASE_ADDR;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = AR_LO;
                end
            end
            AR_LO: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = R_LO;
                end
            end
            R_LO: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d = {32'b0, rdata};
                    err_d  = (rresp != 2'b00);
                    // An errored low word ends the transaction early.
                    state_d = (rresp != 2'b00) ? RESP : AR_HI;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            AR_HI: begin
                arvalid = 1'b1;
                araddr  = BASE_ADDR + 32'd4;
                if (arready) begin
                    state_d = R_HI;
                end
            end
            R_HI: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d[63:32] = rdata;
                    err_d         = (rresp != 2'b00);
                    state_d       = RESP;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_mtime_reader.sv
// Bench for mtime_reader: randomized client/slave stimulus checked every
// cycle against a transaction-level model, plus directed literal checks.

module tb_mtime_reader;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;

    mtime_reader #(
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rresp     (rresp)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Transaction-level model: busy from accept to response accept,
    // m_out = a read address was accepted and its data is still owed.
    bit          m_busy = 0;
    bit          m_resp = 0;
    bit          m_out = 0;
    int          m_nread = 0;
    int          m_wait = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic [63:0] m_data = '0;
    logic        m_err = 1'b0;
    logic [31:0] m_lo = '0;
    int          t_acc = 0;
    logic [31:0] ar_log[$];

    int          p_req = 0;
    int          p_rr = 100;
    int          p_err = 0;
    int          max_ar = 0;
    int          max_r = 0;
    int          ar_fix = -1;
    bit          junk = 0;
    bit          r_never = 0;
    bit          stale_rv = 0;
    bit          rst_next = 1;
    bit          use_fix = 0;
    logic [31:0] fix_lo = '0;
    logic [31:0] fix_hi = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int new_ar();
        return (ar_fix >= 0) ? ar_fix : int'($urandom_range(max_ar));
    endfunction

    task automatic compare();
        bit arp;
        bit rp;
        arp = m_busy && !m_resp && !m_out;
        rp  = m_busy && !m_resp && m_out;
        chk("req_ready", req_ready, !m_busy);
        chk("resp_valid", resp_valid, m_resp);
        chk("arvalid", arvalid, arp);
        chk("rready", rready, rp);
        if (arp) begin
            chk("araddr", araddr, (m_nread == 0) ? BASE : BASE + 32'd4);
        end
        if (m_resp) begin
            chk("resp_data", resp_data, m_data);
            chk("resp_err", resp_err, m_err);
        end
    endtask

    task automatic drive();
        bit arp;
        bit rp;
        arp = m_busy && !m_resp && !m_out;
        rp  = m_busy && !m_resp && m_out;
        rst        = rst_next;
        req_valid  = ($urandom_range(99) < p_req);
        resp_ready = ($urandom_range(99) < p_rr);
        if (arp) begin
            arready = (ar_cnt == 0);
        end else begin
            arready = junk && ($urandom_range(1) == 1);
        end
        rdata = $urandom;
        rresp = 2'($urandom_range(3));
        if (rp) begin
            rvalid = !r_never && (r_cnt == 0);
            if (use_fix) begin
                rdata = (m_nread == 0) ? fix_lo : fix_hi;
            end
            rresp = ($urandom_range(99) < p_err) ?
                    2'($urandom_range(3, 1)) : 2'b00;
        end else begin
            rvalid = stale_rv || (junk && $urandom_range(1) == 1);
        end
    endtask

    task automatic advance();
        bit arp;
        bit rp;
        arp = m_busy && !m_resp && !m_out;
        rp  = m_busy && !m_resp && m_out;
        if (arvalid === 1'b1 && arready && !rst) begin
            ar_log.push_back(araddr);
        end
        if (rst) begin
            m_busy = 0;
            m_resp = 0;
            m_out  = 0;
        end else if (m_resp) begin
            if (resp_ready) begin
                m_resp = 0;
                m_busy = 0;
            end
        end else if (rp) begin
            if (rvalid) begin
                m_out = 0;
                if (m_nread == 0) begin
                    m_lo   = rdata;
                    m_data = {32'b0, rdata};
                    m_err  = (rresp != 2'b00);
                    if (m_err) begin
                        m_resp = 1;
                    end else begin
                        m_nread = 1;
                        ar_cnt  = new_ar();
                    end
                end else begin
                    m_data = {rdata, m_lo};
                    m_err  = (rresp != 2'b00);
                    m_resp = 1;
                end
            end else begin
                if (r_cnt > 0) r_cnt--;
`ifdef MTIME_READER_TIMEOUT_EN
                if (m_wait == TO) begin
                    m_resp = 1;
                    m_err  = 1'b1;
                    m_data = (m_nread == 0) ? 64'h0 : {32'b0, m_lo};
                end else begin
                    m_wait++;
                end
`endif
            end
        end else if (arp) begin
            if (arready) begin
                m_out  = 1;
                m_wait = 0;
                r_cnt  = int'($urandom_range(max_r));
            end else if (ar_cnt > 0) begin
                ar_cnt--;
            end
        end else if (req_valid) begin
            m_busy  = 1;
            m_nread = 0;
            m_out   = 0;
            ar_cnt  = new_ar();
            t_acc   = cyc;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        compare();
        drive();
        advance();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_resp_data"}, resp_data, 64'h0);
        chk({tag, "_araddr"}, araddr, 32'h1001_0000);
    endtask

    task automatic quiesce();
        int n;
        n = 0;
        p_req = 0;
        p_rr = 100;
        r_never = 0;
        junk = 0;
        while (m_busy && n < 300) begin
            cycle();
            n++;
        end
        cycle();
        chk("drain_idle", req_ready, 1);
    endtask

    task automatic accept();
        p_req = 100;
        cycle();
        p_req = 0;
    endtask

    task automatic wait_resp(input int lim, output int n);
        n = 0;
        while (resp_valid !== 1'b1 && n < lim) begin
            cycle();
            n++;
        end
        chk("resp_wait_bound", resp_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        @(negedge clk);
        cycle();
        rst_next = 0;
        cycle();
        check_reset_vals("reset");

        // Basic read, minimum latency, fixed timer value.
        use_fix = 1;
        fix_lo = 32'hFFFF_FFF0;
        fix_hi = 32'h0000_0001;
        p_rr = 0;
        ar_log.delete();
        accept();
        wait_resp(20, n);
        chk("basic_latency", cyc - t_acc, 5);
        chk("basic_data", resp_data, 64'h0000_0001_FFFF_FFF0);
        chk("basic_err", resp_err, 0);
        chk("basic_nreads", ar_log.size(), 2);
        if (ar_log.size() == 2) begin
            chk("basic_addr0", ar_log[0], 32'h1001_0000);
            chk("basic_addr1", ar_log[1], 32'h1001_0004);
        end
        quiesce();

        // Address backpressure and held response.
        use_fix = 0;
        ar_fix = 7;
        p_rr = 0;
        ar_log.delete();
        accept();
        wait_resp(60, n);
        chk("bp_latency", cyc - t_acc, 19);
        repeat (3) begin
            cycle();
            chk("bp_hold_valid", resp_valid, 1);
        end
        ar_fix = -1;
        quiesce();
        chk("bp_nreads", ar_log.size(), 2);

        // Error on the low read: no high read, zero data.
        use_fix = 1;
        fix_lo = 32'h0;
        p_err = 100;
        p_rr = 0;
        ar_log.delete();
        accept();
        wait_resp(20, n);
        chk("err_data", resp_data, 64'h0);
        chk("err_flag", resp_err, 1);
        repeat (3) cycle();
        quiesce();
        chk("err_nreads", ar_log.size(), 1);
        p_err = 0;

        // Reset while waiting for the high word, then a stale rvalid.
        r_never = 1;
        accept();
        n = 0;
        while (!(m_nread == 1 && m_out) && n < 30) begin
            cycle();
            n++;
        end
        rst_next = 1;
        cycle();
        chk("mid_rst_rready", rready, 1);
        rst_next = 0;
        stale_rv = 1;
        r_never = 0;
        cycle();
        check_reset_vals("mid_rst");
        stale_rv = 0;
        cycle();
        fix_lo = 32'h9ABC_DEF0;
        fix_hi = 32'h1234_5678;
        p_rr = 0;
        accept();
        wait_resp(20, n);
        chk("post_rst_data", resp_data, 64'h1234_5678_9ABC_DEF0);
        chk("post_rst_err", resp_err, 0);
        quiesce();
        use_fix = 0;

`ifdef MTIME_READER_TIMEOUT_EN
        r_never = 1;
        p_rr = 0;
        accept();
        n = 0;
        while (rready !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        wait_resp(20, n);
        chk("to_latency", n, 5);
        chk("to_err", resp_err, 1);
        chk("to_data", resp_data, 64'h0);
        quiesce();
`else
        r_never = 1;
        accept();
        repeat (1000) cycle();
        chk("no_to_valid", resp_valid, 0);
        chk("no_to_rready", rready, 1);
        quiesce();
`endif

        // Randomized traffic with delays, errors and stray handshakes.
        junk = 1;
        max_ar = 3;
        max_r = 4;
        p_err = 15;
        p_req = 60;
        p_rr = 60;
        repeat (3000) cycle();
        quiesce();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
